// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg -- shared types and constants for the sequential multiplier.
//   state_e        : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand width in bits
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : seq_mult_pkg

// File: rtl/seq_mult_rca_adder.sv
// rca_adder -- WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
// Subtraction is obtained by driving cin=1 with an inverted b operand.
// Ports:
//   cin  : carry into bit 0
//   a, b : WIDTH-bit operands
//   s    : WIDTH-bit sum
//   cout : carry out of the top bit
module rca_adder #(
    parameter int WIDTH = 8
) (
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule : rca_adder

// File: rtl/seq_mult.sv
// seq_mult -- shift-and-add sequential multiplier, one multiplier bit per cycle.
// A start accepted in IDLE or DONE captures a/b and runs WIDTH iterations in
// RUN; the product is loaded on the RUN->DONE transition and done pulses for
// the single DONE cycle. Build option: define SEQ_MULT_SIGNED_EN for
// two's-complement operands and product (unsigned when undefined).
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : begin a multiplication (ignored while busy)
//   a, b    : multiplicand / multiplier, WIDTH bits
//   busy    : high while in RUN
//   done    : one-cycle pulse, product valid
//   product : 2*WIDTH-bit result, held until the next RUN->DONE transition
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int              CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    // Holds the multiplier; low product bits shift in from the top.
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic               last_iter;
    logic               add_en;
    logic               sub_en;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               top_bit;   // bit WIDTH of the (WIDTH+1)-bit partial sum

    assign last_iter = (cnt_q == LAST_ITER);
    assign add_en    = acc_lo_q[0];

`ifdef SEQ_MULT_SIGNED_EN
    // The multiplier MSB carries negative weight, so the last step subtracts.
    assign sub_en  = last_iter & add_en;
    // Sign of the true sum of two sign-extended operands.
    assign top_bit = acc_hi_q[WIDTH-1] ^ addend[WIDTH-1] ^ cout;
`else
    assign sub_en  = 1'b0;
    assign top_bit = cout;
`endif

    assign addend = add_en ? (sub_en ? ~mcand_q : mcand_q) : '0;

    rca_adder #(
        .WIDTH (WIDTH)
    ) u_rca (
        .cin  (sub_en),
        .a    (acc_hi_q),
        .b    (addend),
        .s    (sum),
        .cout (cout)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    mcand_d  = a;
                    acc_lo_d = b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_hi_d = {top_bit, sum[WIDTH-1:1]};
                acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = DONE;
                    prod_d  = {top_bit, sum[WIDTH-1:1], sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = prod_q;

endmodule : seq_mult

// File: tb/tb_seq_mult.sv
// tb_seq_mult -- directed self-checking bench for seq_mult at WIDTH=8.
// Edge numbering: "edge 0" is the rising edge that samples an accepted start;
// outputs are sampled on the falling edge following each rising edge.
module tb_seq_mult;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    seq_mult #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a/b with start for exactly one rising edge (edge 0); returns at
    // the falling edge after edge 0 with start low.
    task automatic launch(input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(negedge clk);
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b product=%h, expected 0 0 0000", busy, done, product);
        end
        @(negedge clk);
        @(negedge clk);
        // Release reset with start already high: the first edge must accept it.
        rst_n = 1'b1;
        a     = 8'd2;
        b     = 8'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge_start busy=%b, expected 1", busy);
        end
        for (int k = 1; k <= 8; k++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || product !== 16'h0006) begin
            errors++;
            $display("FAIL reset_first_result done=%b product=%h, expected 1 0006", done, product);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        launch(8'd13, 8'd11);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_edge0 busy=%b done=%b, expected 1 0", busy, done);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || product !== 16'h0006) begin
                errors++;
                $display("FAIL basic_run_edge%0d busy=%b done=%b product=%h, expected 1 0 0006", k, busy, done, product);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || product !== 16'h008F) begin
            errors++;
            $display("FAIL basic_done busy=%b done=%b product=%h, expected 0 1 008f", busy, done, product);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h008F) begin
            errors++;
            $display("FAIL basic_after busy=%b done=%b product=%h, expected 0 0 008f", busy, done, product);
        end
    endtask

    task automatic test_max();
        launch(8'd255, 8'd255);
        for (int k = 1; k <= 8; k++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || product !== 16'hFE01) begin
            errors++;
            $display("FAIL max_product done=%b product=%h, expected 1 fe01", done, product);
        end
        @(negedge clk);
        launch(8'd0, 8'd200);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL zero_run_edge%0d busy=%b done=%b, expected 1 0", k, busy, done);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || product !== 16'h0000) begin
            errors++;
            $display("FAIL zero_product done=%b product=%h, expected 1 0000", done, product);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        launch(8'd7, 8'd9);
        @(negedge clk);                  // after edge 1
        @(negedge clk);                  // after edge 2
        a     = 8'd200;
        b     = 8'd200;
        start = 1'b1;                    // sampled at edge 3, in RUN
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);                  // after edge 4
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_edge4 busy=%b done=%b, expected 1 0", busy, done);
        end
        for (int k = 5; k <= 8; k++) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || product !== 16'h003F) begin
            errors++;
            $display("FAIL ignore_done busy=%b done=%b product=%h, expected 0 1 003f", busy, done, product);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_restart busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a     = 8'd3;
        b     = 8'd4;
        start = 1'b1;
        @(posedge clk);                  // edge 0
        @(negedge clk);
        a     = 8'd5;                    // ignored in RUN, captured from DONE
        b     = 8'd6;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || product !== 16'h003F) begin
                errors++;
                $display("FAIL b2b_run1_edge%0d busy=%b product=%h, expected 1 003f", k, busy, product);
            end
        end
        @(negedge clk);                  // after edge 8
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || product !== 16'h000C) begin
            errors++;
            $display("FAIL b2b_done1 busy=%b done=%b product=%h, expected 0 1 000c", busy, done, product);
        end
        @(negedge clk);                  // after edge 9: start accepted from DONE
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || product !== 16'h000C) begin
            errors++;
            $display("FAIL b2b_restart busy=%b done=%b product=%h, expected 1 0 000c", busy, done, product);
        end
        for (int k = 10; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || product !== 16'h000C) begin
                errors++;
                $display("FAIL b2b_run2_edge%0d busy=%b product=%h, expected 1 000c", k, busy, product);
            end
        end
        @(negedge clk);                  // after edge 17
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || product !== 16'h001E) begin
            errors++;
            $display("FAIL b2b_done2 busy=%b done=%b product=%h, expected 0 1 001e", busy, done, product);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        launch(8'd9, 8'd9);
        for (int k = 1; k <= 3; k++) @(negedge clk);
        @(posedge clk);                  // edge 4
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_outputs busy=%b done=%b product=%h, expected 0 0 0000", busy, done, product);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midreset_no_done active_cycles=%0d, expected 0", done_seen);
        end
        launch(8'd6, 8'd7);
        for (int k = 1; k <= 8; k++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || product !== 16'h002A) begin
            errors++;
            $display("FAIL midreset_next_op done=%b product=%h, expected 1 002a", done, product);
        end
        @(negedge clk);
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed();
        launch(8'hFD, 8'd5);
        for (int k = 1; k <= 8; k++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || product !== 16'hFFF1) begin
            errors++;
            $display("FAIL signed_m3x5 done=%b product=%h, expected 1 fff1", done, product);
        end
        @(negedge clk);
        launch(8'h80, 8'h80);
        for (int k = 1; k <= 8; k++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || product !== 16'h4000) begin
            errors++;
            $display("FAIL signed_m128xm128 done=%b product=%h, expected 1 4000", done, product);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
`ifdef SEQ_MULT_SIGNED_EN
        test_signed();
`else
        test_max();
`endif
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_mult
